// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state encoding and default widths for the memory bus arbiter.
package mem_arb_pkg;
    typedef enum logic [1:0] {IDLE, GRANT, MEM_WAIT, DONE} arb_state_t;
    localparam int DEF_ADDR_W = 12;
    localparam int DEF_DATA_W = 8;
endpackage

// File: rtl/rr_picker.sv
// rr_picker: combinational round-robin pick of the first set request at or after ptr, with wrap.
module rr_picker #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic         found,
    output logic [W-1:0] owner
);
    logic [W-1:0] idx;
    always_comb begin
        found = 1'b0;
        owner = '0;
        idx = ptr;
        for (int i = 0; i < N; i++) begin
            if (!found && req[idx]) begin
                found = 1'b1;
                owner = idx;
            end
            idx = (idx == W'(N - 1)) ? '0 : idx + 1'b1;
        end
    end
endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: round-robin arbiter granting one cache at a time a single byte
// access on the main-memory port, with a per-transaction ack timeout.
module mem_bus_arbiter
    import mem_arb_pkg::*;
#(
    parameter int N_CORES     = 4,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_CORES-1:0]        req_arb,
    input  logic [N_CORES-1:0]        req_rw,
    input  logic [N_CORES*ADDR_W-1:0] req_addr,
    input  logic [N_CORES*DATA_W-1:0] req_wdata,
    output logic [N_CORES-1:0]        gnt_arb,
    output logic [N_CORES-1:0]        done,
    output logic [DATA_W-1:0]         rdata,
    output logic                      err,
    output logic                      mem_req,
    output logic                      mem_rw,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [DATA_W-1:0]         mem_wdata,
    input  logic [DATA_W-1:0]         mem_rdata,
    input  logic                      mem_ack
);
    localparam int OW = $clog2(N_CORES);

    arb_state_t        state, nxt;
    logic              found, rw_l, expire;
    logic [OW-1:0]     pick, owner, rr_ptr;
    logic [ADDR_W-1:0] addr_l;
    logic [DATA_W-1:0] wdata_l;
    logic [7:0]        cnt;

    rr_picker #(.N(N_CORES)) u_pick (
        .req  (req_arb),
        .ptr  (rr_ptr),
        .found(found),
        .owner(pick)
    );

    // ack in the expiry cycle takes the success path below
    assign expire = cnt == 8'(TIMEOUT_CYC - 1);

    always_comb begin
        nxt = state;
        case (state)
            IDLE:     nxt = found ? GRANT : IDLE;
            GRANT:    nxt = MEM_WAIT;
            MEM_WAIT: nxt = (mem_ack || expire) ? DONE : MEM_WAIT;
            default:  nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst)
        if (!rst) state <= IDLE;
        else      state <= nxt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gnt_arb   <= '0;
            done      <= '0;
            err       <= 1'b0;
            rdata     <= '0;
            mem_req   <= 1'b0;
            mem_rw    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            owner     <= '0;
            rr_ptr    <= '0;
            rw_l      <= 1'b0;
            addr_l    <= '0;
            wdata_l   <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: if (found) begin
                    owner   <= pick;
                    rw_l    <= req_rw[pick];
                    addr_l  <= req_addr[pick*ADDR_W +: ADDR_W];
                    wdata_l <= req_wdata[pick*DATA_W +: DATA_W];
                    gnt_arb <= N_CORES'(1) << pick;
                end
                GRANT: begin
                    mem_req   <= 1'b1;
                    mem_rw    <= rw_l;
                    mem_addr  <= addr_l;
                    mem_wdata <= wdata_l;
                    cnt       <= '0;
                end
                MEM_WAIT: if (mem_ack) begin
                    mem_req <= 1'b0;
                    done    <= gnt_arb;
                    if (!mem_rw) rdata <= mem_rdata;
                end else if (expire) begin
                    mem_req <= 1'b0;
                    done    <= gnt_arb;
                    err     <= 1'b1;
                    rdata   <= '0;
                end else begin
                    cnt <= cnt + 8'd1;
                end
                default: begin
                    gnt_arb <= '0;
                    done    <= '0;
                    err     <= 1'b0;
                    rr_ptr  <= (owner == OW'(N_CORES - 1)) ? '0 : owner + 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed plus randomized transactions checked against a
// transaction-level round-robin/memory model.
module tb_mem_bus_arbiter;
    localparam int N = 4, AW = 12, DW = 8, T = 4;

    logic clk = 1'b0, rst = 1'b0;
    logic [N-1:0] req_arb = '0, req_rw = '0;
    logic [N*AW-1:0] req_addr = '0;
    logic [N*DW-1:0] req_wdata = '0;
    logic [N-1:0] gnt_arb, done, g;
    logic [DW-1:0] rdata, mem_wdata, mem_rdata = '0;
    logic err, mem_req, mem_rw, mem_ack = 1'b0;
    logic [AW-1:0] mem_addr;

    int total = 0, bad = 0, ptr_m = 0, n;
    logic [DW-1:0] rd_m = '0;

    mem_bus_arbiter #(.N_CORES(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(T)) dut (
        .clk(clk), .rst(rst), .req_arb(req_arb), .req_rw(req_rw), .req_addr(req_addr),
        .req_wdata(req_wdata), .gnt_arb(gnt_arb), .done(done), .rdata(rdata), .err(err),
        .mem_req(mem_req), .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        @(negedge clk);
        chk("onehot0", 32'($onehot0(gnt_arb)), 1);
        chk("done_sub", 32'((done & ~gnt_arb) == '0), 1);
    endtask

    function automatic int pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++)
            if (r[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    task automatic set_core(input int c, input logic rw, input logic [AW-1:0] a, input logic [DW-1:0] w);
        req_arb[c] = 1'b1;
        req_rw[c] = rw;
        req_addr[c*AW +: AW] = a;
        req_wdata[c*DW +: DW] = w;
    endtask

    // d = MEM_WAIT cycle index carrying mem_ack (>= T means none in time); rdv < 0 = random data
    task automatic do_txn(input int exp_wait, input int d, input bit wd, input int rdv, output logic [N-1:0] gs);
        int own, cnt, j, jd;
        logic rw;
        logic [AW-1:0] a;
        logic [DW-1:0] w, ackd, rexp;
        bit to;
        gs = '0;
        own = pick(req_arb, ptr_m);
        chk("req_present", 32'(own >= 0), 1);
        if (own < 0) return;
        rw = req_rw[own];
        a = req_addr[own*AW +: AW];
        w = req_wdata[own*DW +: DW];
        cnt = 0;
        do begin
            step;
            mem_ack = 1'b0;
            cnt++;
        end while (gnt_arb == '0 && cnt < 8);
        chk("gnt_lat", cnt, exp_wait);
        gs = gnt_arb;
        chk("gnt", gnt_arb, 1 << own);
        chk("req_early", mem_req, 0);
        step;
        chk("mem_req", mem_req, 1);
        chk("mem_rw", mem_rw, rw);
        chk("mem_addr", mem_addr, a);
        chk("mem_wdata", mem_wdata, w);
        ackd = '0;
        for (j = 0; j < 8; j++) begin
            mem_ack = (j == d);
            mem_rdata = rdv >= 0 ? DW'(rdv) : DW'($urandom);
            if (j == d) ackd = mem_rdata;
            if (wd && j == 0) req_arb[own] = 1'b0;
            step;
            mem_ack = 1'b0;
            if (done != '0) break;
            chk("hold", {mem_req, mem_rw, mem_addr, mem_wdata}, {1'b1, rw, a, w});
        end
        to = d >= T;
        jd = to ? T - 1 : d;
        rexp = to ? '0 : (rw ? rd_m : ackd);
        chk("done_cyc", j, jd);
        chk("done", done, 1 << own);
        chk("err", err, to);
        chk("rdata", rdata, rexp);
        chk("req_drop", mem_req, 0);
        rd_m = rexp;
        ptr_m = (own + 1) % N;
        if (d == T) mem_ack = 1'b1;  // stray ack lands in the DONE cycle
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_a", {gnt_arb, done, err, mem_req, mem_rw}, 0);
        chk("rst_b", {mem_addr, mem_wdata, rdata}, 0);
        rst = 1'b1;
        step;
        chk("idle_gnt", gnt_arb, 0);

        set_core(1, 1'b0, 12'h0A5, 8'h00);
        do_txn(1, 2, 1'b0, 8'h3C, g);
        for (int c = 0; c < N; c++) set_core(c, 1'b0, AW'($urandom), DW'($urandom));
        do_txn(2, 0, 1'b0, -1, g);
        chk("rr_after_read", g, 4'b0100);

        rst = 1'b0;
        req_arb = '0;
        step;
        rst = 1'b1;
        ptr_m = 0;
        rd_m = '0;
        for (int c = 0; c < N; c++) set_core(c, 1'b0, AW'($urandom), DW'($urandom));
        for (int i = 0; i < N; i++) begin
            do_txn(i == 0 ? 1 : 2, 0, 1'b0, -1, g);
            chk("cont_order", g, 1 << i);
        end

        req_arb = '0;
        set_core(3, 1'b1, 12'hFFF, 8'h81);
        do_txn(2, 3, 1'b0, -1, g);
        req_arb = '0;
        set_core(2, 1'b0, 12'h123, 8'h00);
        do_txn(2, 99, 1'b0, -1, g);
        req_arb = '0;
        set_core(1, 1'b0, 12'h456, 8'h00);
        do_txn(2, T, 1'b0, -1, g);
        do_txn(2, 1, 1'b0, 8'h5A, g);
        req_arb = '0;
        set_core(0, 1'b1, 12'h010, 8'h77);
        do_txn(2, 2, 1'b1, -1, g);
        repeat (3) step;
        chk("idle_after", {gnt_arb, done, mem_req}, 0);

        set_core(2, 1'b0, 12'h2AA, 8'h00);
        n = 0;
        while (!mem_req && n < 10) begin
            step;
            n++;
        end
        chk("mr_before_rst", mem_req, 1);
        #2 rst = 1'b0;
        #1;
        chk("async_rst", {mem_req, gnt_arb, done, err}, 0);
        chk("async_rdata", rdata, 0);
        @(negedge clk);
        rst = 1'b1;
        ptr_m = 0;
        rd_m = '0;
        for (int c = 0; c < N; c++) set_core(c, 1'b0, AW'($urandom), DW'($urandom));
        do_txn(1, 1, 1'b0, -1, g);
        chk("post_rst", g, 4'b0001);

        repeat (300) begin
            for (int c = 0; c < N; c++) begin
                if (g[c]) begin
                    req_arb[c] = 1'($urandom);
                    if (req_arb[c]) set_core(c, 1'($urandom), AW'($urandom), DW'($urandom));
                end else if (!req_arb[c] && $urandom_range(2) == 0) begin
                    set_core(c, 1'($urandom), AW'($urandom), DW'($urandom));
                end
            end
            if (req_arb == '0) set_core($urandom_range(N - 1), 1'($urandom), AW'($urandom), DW'($urandom));
            do_txn(2, $urandom_range(5), $urandom_range(4) == 0, -1, g);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
